// File: rtl/stage_info_pipe.sv
// Five-stage instruction/hazard info pipe: decodes the D-stage instruction into use/new times and register numbers.
// Latency: one register per stage (F->D->E->M->W). There is no backpressure; the hazard unit stalls D and inserts E bubbles.
module stage_info_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_F,
    input  logic        IF_to_D_enabled,
    input  logic        reset_D_to_E,
    output logic [31:0] Instr_D,
    output logic [31:0] Instr_E,
    output logic [31:0] Instr_M,
    output logic [31:0] Instr_W,
    output logic [4:0]  T_use_rs,
    output logic [4:0]  T_use_rt,
    output logic [4:0]  T_new_E,
    output logic [4:0]  T_new_M,
    output logic [4:0]  T_new_W,
    output logic [4:0]  rs_need_D,
    output logic [4:0]  rt_need_D,
    output logic [4:0]  rs_need_E,
    output logic [4:0]  rt_need_E,
    output logic [4:0]  WriteReg_need_E,
    output logic [4:0]  WriteReg_need_M,
    output logic [4:0]  WriteReg_need_W,
    output logic [31:0] stall_count
);
    logic [31:0] instr_d_q, instr_e_q, instr_m_q, instr_w_q;
    logic [31:0] instr_d_d, instr_e_d, instr_m_d, instr_w_d;
    logic [4:0]  tnew_e_q, tnew_m_q, tnew_w_q, tnew_e_d, tnew_m_d, tnew_w_d;
    logic [4:0]  wreg_e_q, wreg_m_q, wreg_w_q, wreg_e_d, wreg_m_d, wreg_w_d;
    logic [4:0]  rs_e_q, rt_e_q, rs_e_d, rt_e_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic [5:0]  op, fn;
    logic        is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;
    logic [4:0]  tnew_dec, wreg_dec;

    assign op      = instr_d_q[31:26];
    assign fn      = instr_d_q[5:0];
    assign is_addu = (op == 6'b000000) && (fn == 6'b100001);
    assign is_subu = (op == 6'b000000) && (fn == 6'b100011);
    assign is_jr   = (op == 6'b000000) && (fn == 6'b001000);
    assign is_ori  = (op == 6'b001101);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_lui  = (op == 6'b001111);
    assign is_jal  = (op == 6'b000011);

    // D-stage decode; anything unrecognised (including j) behaves as a nop.
    always_comb begin
        T_use_rs = 5'd3;
        T_use_rt = 5'd3;
        tnew_dec = 5'd0;
        wreg_dec = 5'd0;
        if (is_beq || is_jr)
            T_use_rs = 5'd0;
        else if (is_addu || is_subu || is_ori || is_lw || is_sw)
            T_use_rs = 5'd1;
        if (is_beq)
            T_use_rt = 5'd0;
        else if (is_addu || is_subu)
            T_use_rt = 5'd1;
        else if (is_sw)
            T_use_rt = 5'd2;
        if (is_addu || is_subu || is_ori || is_lui)
            tnew_dec = 5'd1;
        else if (is_lw)
            tnew_dec = 5'd2;
        if (is_addu || is_subu)
            wreg_dec = instr_d_q[15:11];
        else if (is_ori || is_lw || is_lui)
            wreg_dec = instr_d_q[20:16];
        else if (is_jal)
            wreg_dec = 5'd31;
    end

    always_comb begin
        instr_d_d     = IF_to_D_enabled ? Instr_F : instr_d_q;
        instr_e_d     = instr_d_q;
        tnew_e_d      = tnew_dec;
        wreg_e_d      = wreg_dec;
        rs_e_d        = instr_d_q[25:21];
        rt_e_d        = instr_d_q[20:16];
        instr_m_d     = instr_e_q;
        instr_w_d     = instr_m_q;
        tnew_m_d      = (tnew_e_q == 5'd0) ? 5'd0 : tnew_e_q - 5'd1;
        tnew_w_d      = (tnew_m_q == 5'd0) ? 5'd0 : tnew_m_q - 5'd1;
        wreg_m_d      = wreg_e_q;
        wreg_w_d      = wreg_m_q;
        stall_count_d = stall_count_q;
        if (reset_D_to_E) begin
            instr_e_d = 32'd0;
            tnew_e_d  = 5'd0;
            wreg_e_d  = 5'd0;
            rs_e_d    = 5'd0;
            rt_e_d    = 5'd0;
            if (stall_count_q != 32'hFFFF_FFFF)
                stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d_q     <= 32'd0;
            instr_e_q     <= 32'd0;
            instr_m_q     <= 32'd0;
            instr_w_q     <= 32'd0;
            tnew_e_q      <= 5'd0;
            tnew_m_q      <= 5'd0;
            tnew_w_q      <= 5'd0;
            wreg_e_q      <= 5'd0;
            wreg_m_q      <= 5'd0;
            wreg_w_q      <= 5'd0;
            rs_e_q        <= 5'd0;
            rt_e_q        <= 5'd0;
            stall_count_q <= 32'd0;
        end else begin
            instr_d_q     <= instr_d_d;
            instr_e_q     <= instr_e_d;
            instr_m_q     <= instr_m_d;
            instr_w_q     <= instr_w_d;
            tnew_e_q      <= tnew_e_d;
            tnew_m_q      <= tnew_m_d;
            tnew_w_q      <= tnew_w_d;
            wreg_e_q      <= wreg_e_d;
            wreg_m_q      <= wreg_m_d;
            wreg_w_q      <= wreg_w_d;
            rs_e_q        <= rs_e_d;
            rt_e_q        <= rt_e_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign Instr_D         = instr_d_q;
    assign Instr_E         = instr_e_q;
    assign Instr_M         = instr_m_q;
    assign Instr_W         = instr_w_q;
    assign T_new_E         = tnew_e_q;
    assign T_new_M         = tnew_m_q;
    assign T_new_W         = tnew_w_q;
    assign rs_need_D       = instr_d_q[25:21];
    assign rt_need_D       = instr_d_q[20:16];
    assign rs_need_E       = rs_e_q;
    assign rt_need_E       = rt_e_q;
    assign WriteReg_need_E = wreg_e_q;
    assign WriteReg_need_M = wreg_m_q;
    assign WriteReg_need_W = wreg_w_q;
    assign stall_count     = stall_count_q;
endmodule
